// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: display value/mask load bus and scan outputs of seven_seg_scan_ctrl
interface seven_seg_scan_if;
   logic [15:0] value;
   logic [3:0]  blank_mask;
   logic [3:0]  dp_mask;
   logic        load;
   logic [3:0]  hex_out;
   logic [3:0]  an;
   logic        dp_n;
   logic        load_ack;
   logic        frame_tick;
   modport master (output value, blank_mask, dp_mask, load, input hex_out, an, dp_n, load_ack, frame_tick);
   modport slave  (input value, blank_mask, dp_mask, load, output hex_out, an, dp_n, load_ack, frame_tick);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit common-anode scan controller with ghost gap and frame-aligned commit.
// Define SEVEN_SEG_LZB_EN to compile in leading-zero blanking.
module seven_seg_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int GHOST = 500
) (
   input logic             clk,
   input logic             rst,
   seven_seg_scan_if.slave bus
);
   localparam int CW = $clog2(DIV);
   typedef enum logic {S_GHOST, S_DRIVE} slot_t;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          pend;
   logic [15:0]   pend_value, shown_value;
   logic [3:0]    pend_blank, pend_dp, shown_blank, shown_dp, lzb;
   slot_t         slot;
   logic          last, wrap, blanked;
   always_comb begin
      last = cnt == CW'(DIV - 1);
      wrap = last && (idx == 2'd3);
      slot = (cnt < CW'(GHOST)) ? S_GHOST : S_DRIVE;
      lzb  = '0;
`ifdef SEVEN_SEG_LZB_EN
      lzb[3] = shown_value[15:12] == 4'd0;
      lzb[2] = shown_value[15:8] == 8'd0;
      lzb[1] = shown_value[15:4] == 12'd0;
`endif
      blanked = shown_blank[idx] | lzb[idx];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         idx            <= '0;
         pend           <= 1'b0;
         pend_value     <= '0;
         pend_blank     <= '0;
         pend_dp        <= '0;
         shown_value    <= '0;
         shown_blank    <= 4'hf;
         shown_dp       <= '0;
         bus.hex_out    <= '0;
         bus.an         <= 4'hf;
         bus.dp_n       <= 1'b1;
         bus.load_ack   <= 1'b0;
         bus.frame_tick <= 1'b0;
      end else begin
         cnt            <= last ? '0 : cnt + 1'b1;
         idx            <= last ? idx + 1'b1 : idx;
         bus.hex_out    <= shown_value[4*idx +: 4];
         bus.an         <= (slot == S_GHOST || blanked) ? 4'hf : ~(4'b0001 << idx);
         bus.dp_n       <= (slot == S_GHOST) || blanked || !shown_dp[idx];
         bus.frame_tick <= wrap;
         bus.load_ack   <= wrap && (pend || bus.load);
         // a load on the wrap cycle bypasses pending and commits at once
         if (wrap) begin
            pend <= 1'b0;
            if (bus.load) begin
               shown_value <= bus.value;
               shown_blank <= bus.blank_mask;
               shown_dp    <= bus.dp_mask;
            end else if (pend) begin
               shown_value <= pend_value;
               shown_blank <= pend_blank;
               shown_dp    <= pend_dp;
            end
         end else if (bus.load) begin
            pend       <= 1'b1;
            pend_value <= bus.value;
            pend_blank <= bus.blank_mask;
            pend_dp    <= bus.dp_mask;
         end
      end
   end
endmodule
